// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide for the EX stage.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational MUL path.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [9:0]       funct_i,
  input  logic [WIDTH-1:0] RS1data_i,
  input  logic [WIDTH-1:0] RS2data_i,
  input  logic [4:0]       RDaddr_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       RDaddr_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_V =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0] f3;
  logic       m_op;
  logic       is_div;
  logic       is_sgn;
  logic       div_zero;
  logic       div_ovf;
  logic       special;
  logic       fast_mul;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic             mul_q;
  logic             rem_q;
  logic             negq_q;
  logic             negr_q;
  logic [4:0]       rd_q;
  logic [4:0]       rdo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] fin;

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  assign f3       = funct_i[2:0];
  assign m_op     = valid_i &
                    (funct_i[9:3] == 7'b0000001);
  assign is_div   = f3[2];
  assign is_sgn   = f3[2] & ~f3[0];
  assign div_zero = is_div & (RS2data_i == '0);
  assign div_ovf  = is_sgn &
                    (RS1data_i == MIN_V) &
                    (&RS2data_i);
  assign special  = div_zero | div_ovf;

`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul = ~is_div;
`else
  assign fast_mul = 1'b0;
`endif

  assign abs_a = (is_sgn & RS1data_i[WIDTH-1]) ?
                 (~RS1data_i + 1'b1) : RS1data_i;
  assign abs_b = (is_sgn & RS2data_i[WIDTH-1]) ?
                 (~RS2data_i + 1'b1) : RS2data_i;

  // Restoring-divide trial subtract: shift in next dividend bit.
  assign sh   = {acc_q, x_q[WIDTH-1]};
  assign diff = sh - {1'b0, y_q};

  // Final value from the working registers, with sign fixups.
  always_comb begin
    fin = x_q;
    unique case (1'b1)
      mul_q:   fin = acc_q;
      rem_q:   fin = negr_q ? (~acc_q + 1'b1) : acc_q;
      default: fin = negq_q ? (~x_q + 1'b1) : x_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and pipeline stall.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (m_op) begin
          stall_o = 1'b1;
          state_d = (special | fast_mul) ?
                    S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        stall_o = 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mul_q  <= 1'b0;
      rem_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      rd_q   <= '0;
      rdo_q  <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      res_q  <= '0;
    end else if (state_q == S_IDLE) begin
      if (m_op) begin
        rd_q   <= RDaddr_i;
        mul_q  <= ~is_div;
        rem_q  <= is_div & f3[1];
        cnt_q  <= CW'(WIDTH-1);
        negq_q <= 1'b0;
        negr_q <= 1'b0;
        acc_q  <= '0;
        x_q    <= RS1data_i;
        y_q    <= RS2data_i;
        unique case (1'b1)
          ~is_div: begin
`ifdef MULDIV_FAST_MUL_EN
            acc_q <= RS1data_i * RS2data_i;
`endif
          end
          div_zero: begin
            x_q   <= '1;
            acc_q <= RS1data_i;
          end
          div_ovf: begin
            x_q   <= MIN_V;
            acc_q <= '0;
          end
          default: begin
            x_q    <= abs_a;
            y_q    <= abs_b;
            negq_q <= is_sgn &
                      (RS1data_i[WIDTH-1] ^
                       RS2data_i[WIDTH-1]);
            negr_q <= is_sgn & RS1data_i[WIDTH-1];
          end
        endcase
      end
    end else if (state_q == S_CALC) begin
      cnt_q <= cnt_q - CW'(1);
      if (mul_q) begin
        if (y_q[0]) acc_q <= acc_q + x_q;
        x_q <= {x_q[WIDTH-2:0], 1'b0};
        y_q <= {1'b0, y_q[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
        acc_q <= diff[WIDTH-1:0];
        x_q   <= {x_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_q <= sh[WIDTH-1:0];
        x_q   <= {x_q[WIDTH-2:0], 1'b0};
      end
    end else if (state_q == S_DONE) begin
      res_q <= fin;
      rdo_q <= rd_q;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign result_o = done_o ? fin : res_q;
  assign RDaddr_o = done_o ? rd_q : rdo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized + directed bench with reference model.
// Model tracks latency/results from cycle numbers of accepted ops.
module tb_ex_muldiv_unit;
  localparam int W = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [9:0]  funct_i;
  logic [31:0] RS1data_i;
  logic [31:0] RS2data_i;
  logic [4:0]  RDaddr_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  RDaddr_o;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .valid_i(valid_i),
    .funct_i(funct_i),
    .RS1data_i(RS1data_i),
    .RS2data_i(RS2data_i),
    .RDaddr_i(RDaddr_i),
    .stall_o(stall_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .result_o(result_o),
    .RDaddr_o(RDaddr_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  bit          chk_en = 1'b0;
  bit          m_active = 1'b0;
  int          m_a;
  int          m_lat;
  logic [31:0] m_res;
  logic [4:0]  m_rd;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(
    logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (f3)
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF)
          return MINV;
        return sa / sb;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF)
          return 0;
        return sa % sb;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b111: return (b == 0) ? a : a % b;
      default: return a * b;
    endcase
  endfunction

  function automatic int lat_of(
    logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if (f3[2] && !f3[0] && a == MINV &&
        b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return W + 1;
  endfunction

  // Compare every cycle against the model's timeline.
  always @(negedge clk_i) begin
    logic        es;
    logic        eb;
    logic        ed;
    logic [31:0] er;
    logic [4:0]  ea;
    if (chk_en) begin
      es = 1'b0;
      eb = 1'b0;
      ed = 1'b0;
      if (m_active) begin
        es = (cyc < m_a + m_lat);
        eb = (cyc > m_a);
        ed = (cyc == m_a + m_lat);
      end
      er = ed ? m_res : last_res;
      ea = ed ? m_rd : last_rd;
      chk("stall", 32'(stall_o), 32'(es));
      chk("busy", 32'(busy_o), 32'(eb));
      chk("done", 32'(done_o), 32'(ed));
      chk("result", result_o, er);
      chk("rdaddr", 32'(RDaddr_o), 32'(ea));
      if (ed) begin
        last_res = m_res;
        last_rd  = m_rd;
        m_active = 1'b0;
      end
    end
  end

  // Present an instruction; register it with the model if M-op.
  task automatic start_op(logic v, logic [6:0] f7,
                          logic [2:0] f3, logic [31:0] a,
                          logic [31:0] b, logic [4:0] rd,
                          output int lat);
    valid_i   = v;
    funct_i   = {f7, f3};
    RS1data_i = a;
    RS2data_i = b;
    RDaddr_i  = rd;
    lat = 0;
    if (v && f7 == 7'b0000001) begin
      lat      = lat_of(f3, a, b);
      m_a      = cyc;
      m_lat    = lat;
      m_res    = ref_op(f3, a, b);
      m_rd     = rd;
      m_active = 1'b1;
    end
  endtask

  task automatic do_op(logic v, logic [6:0] f7,
                       logic [2:0] f3, logic [31:0] a,
                       logic [31:0] b, logic [4:0] rd);
    int lat;
    start_op(v, f7, f3, a, b, rd, lat);
    repeat (lat + 1) @(posedge clk_i);
    #1;
    if (lat != 0) chk("op_retired", 32'(m_active), 0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MINV;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    rst_i     = 1'b1;
    valid_i   = 1'b0;
    funct_i   = '0;
    RS1data_i = '0;
    RS2data_i = '0;
    RDaddr_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i  = 1'b0;
    chk_en = 1'b1;
    @(posedge clk_i);
    #1;

    chk("pin_mul", ref_op(3'b000, 7, 32'hFFFF_FFFD),
        32'hFFFF_FFEB);
    chk("pin_div", ref_op(3'b100, 32'hFFFF_FFF9, 2),
        32'hFFFF_FFFD);
    chk("pin_rem", ref_op(3'b110, 32'hFFFF_FFF9, 2),
        32'hFFFF_FFFF);
    chk("pin_divu", ref_op(3'b101, 32'hFFFF_FFFF, 16),
        32'h0FFF_FFFF);
    chk("pin_remu", ref_op(3'b111, 32'hFFFF_FFFF, 16),
        32'h0000_000F);
    chk("pin_div0", ref_op(3'b100, 5, 0), 32'hFFFF_FFFF);
    chk("pin_rem0", ref_op(3'b110, 5, 0), 32'h5);
    chk("pin_ovfq", ref_op(3'b100, MINV, 32'hFFFF_FFFF),
        MINV);
    chk("pin_ovfr", ref_op(3'b110, MINV, 32'hFFFF_FFFF),
        32'h0);
    chk("pin_lat_div0", 32'(lat_of(3'b100, 5, 0)), 1);
    chk("pin_lat_divu", 32'(lat_of(3'b101, 100, 7)), 33);

    do_op(1, 7'h01, 3'b000, 7, 32'hFFFF_FFFD, 5);
    chk("mul_lit", result_o, 32'hFFFF_FFEB);
    chk("mul_rd", 32'(RDaddr_o), 5);
    do_op(1, 7'h01, 3'b111, 100, 7, 6);
    chk("remu_lit", result_o, 2);
    do_op(1, 7'h01, 3'b100, 32'hFFFF_FFF9, 2, 1);
    do_op(1, 7'h01, 3'b110, 32'hFFFF_FFF9, 2, 2);
    do_op(1, 7'h01, 3'b101, 32'hFFFF_FFFF, 16, 3);
    do_op(1, 7'h01, 3'b111, 32'hFFFF_FFFF, 16, 4);
    do_op(1, 7'h01, 3'b100, 5, 0, 7);
    do_op(1, 7'h01, 3'b110, 5, 0, 8);
    chk("rem0_lit", result_o, 5);
    do_op(1, 7'h01, 3'b100, MINV, 32'hFFFF_FFFF, 9);
    do_op(1, 7'h01, 3'b110, MINV, 32'hFFFF_FFFF, 10);
    do_op(1, 7'h00, 3'b000, 3, 4, 11);
    do_op(1, 7'h01, 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 12);

    start_op(1, 7'h01, 3'b101, 32'hDEAD_BEEF, 3, 13, lat);
    repeat (10) @(posedge clk_i);
    #1;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i    = 1'b0;
    m_active = 1'b0;
    last_res = '0;
    last_rd  = '0;
    @(negedge clk_i);
    chk("rst_result", result_o, 0);
    @(posedge clk_i);
    #1;
    do_op(1, 7'h01, 3'b101, 100, 7, 14);
    chk("divu_lit", result_o, 14);

    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k == 0)
        do_op(0, 7'h01, 3'($urandom), $urandom, $urandom,
              5'($urandom));
      else if (k == 1)
        do_op(1, ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
              3'($urandom), $urandom, $urandom,
              5'($urandom));
      else
        do_op(1, 7'h01, 3'($urandom), rnd_val(), rnd_val(),
              5'($urandom));
    end

    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
